btb_controller: RTL and testbench
=================================

# btb_controller

Sequencer for the `branch_target_buffer`. It sits between the fetch stage, the execute stage and the single BTB instance. It issues fetch lookups and holds the read address stable across the one-cycle read latency so the BTB's combinational `miss` is valid. It queues resolved-branch updates from execute and drains them through the BTB write port, and it sequences full-table invalidation (flush) through the BTB's `sync_rst`.

## Interface
- `PC_BITWIDTH`, 30, word-address width of PCs and targets
- `LOW_PC_BITWIDTH`, 6, BTB index width; must match the BTB instance
- `UPD_DEPTH`, 4, update queue entries; power of two, ≥2

Ports:
- `clk`  in  1  sole clock
- `sync_rst_n`  in  1  reset, synchronous, active-low
- `clk_en`  in  1  global stall; low freezes all state
- `lu_valid` / `lu_ready`  in/out  1  fetch lookup handshake
- `lu_pc`  in  PC_BITWIDTH  lookup PC
- `lu_rsp_valid`  out  1  lookup response strobe
- `lu_rsp_hit`  out  1  1 = `lu_rsp_target` usable
- `lu_rsp_target`  out  PC_BITWIDTH  predicted target
- `upd_valid` / `upd_ready`  in/out  1  execute update handshake
- `upd_pc`, `upd_target`  in  PC_BITWIDTH  branch PC and resolved target
- `flush_req`  in  1  invalidate all entries
- `flush_busy`  out  1  flush in progress
- `btb_clk_en`, `btb_sync_rst`, `btb_we`  out  1  BTB controls; `btb_sync_rst` is active-high
- `btb_r_address`, `btb_w_address`, `btb_data_in`  out  PC_BITWIDTH  BTB address and data
- `btb_data_out`  in  PC_BITWIDTH  BTB read data
- `btb_miss`  in  1  BTB miss flag

## Operation
- FSM states are FLUSH and RUN.
  - Reset enters FLUSH.
  - FLUSH lasts one cycle, then goes to RUN.
  - RUN goes to FLUSH on `flush_req & clk_en`.
- `btb_sync_rst = ~sync_rst_n | (state==FLUSH)`. `flush_busy = (state==FLUSH)`.
- `btb_clk_en = clk_en`.
- Lookup:
  - `lu_ready = RUN & ~rsp_pend_q & ~flush_req`.
  - Accept is `lu_valid & lu_ready & clk_en`.
  - `btb_r_address` = `lu_pc` in the accept cycle, otherwise `lu_pc_q`, which is captured on accept.
- Response:
  - In the cycle after accept, `lu_rsp_valid=1`.
  - `lu_rsp_target = btb_data_out`.
  - `lu_rsp_hit = ~btb_miss & ~kill_q`.
- `kill_q` is set at the accept edge if either of these holds:
  - a BTB write to the same index occurs on that edge (the read buffer is stale while `tag_valid` is already updated), or
  - the FSM enters FLUSH on that edge.
- Update queue:
  - Circular FIFO of {pc, target}.
  - `upd_ready = RUN & ~full & ~flush_req`.
  - Head is written when `RUN & ~empty & clk_en`: `btb_we=1`, `btb_w_address`=head pc, `btb_data_in`=head target, pop on the same edge.
  - One write per cycle; no bypass, so an entry is written at the earliest one cycle after acceptance.
- Flush: entering FLUSH empties the queue; pending updates are discarded.
- Simultaneous events:
  - Lookup and update in the same cycle both proceed; they use separate BTB ports.
  - Push and pop in the same cycle leave the count unchanged.
  - `flush_req` wins over any new handshake.
- Counter widths: pointers are `$clog2(UPD_DEPTH)` bits and wrap naturally; the count is `$clog2(UPD_DEPTH)+1` bits.

## Timing
- Reset values:
  - state = FLUSH
  - `lu_rsp_valid=0`, `lu_rsp_hit=0`
  - `btb_we=0`, `btb_sync_rst=1`, `flush_busy=1` (FLUSH lasts one cycle after `sync_rst_n` rises)
  - `lu_ready=0`, `upd_ready=0`
  - queue empty, `rsp_pend_q=0`, `kill_q=0`
- Lookup latency is 1 cycle; issue rate is one lookup every 2 cycles (`lu_ready` low during the response cycle).
- Update drain rate is 1 per cycle; full-queue backpressure is visible on `upd_ready` in the same cycle.
- `clk_en=0`:
  - No accepts, pops or state changes.
  - `lu_rsp_valid` holds its value and `btb_r_address` holds, so the response remains valid.
  - FLUSH still clears the BTB, because the BTB reset ignores `clk_en`.
- Reset asserted mid-operation drops the pending response, the queue and `kill_q` on that edge.

## Structure
- Package `btb_ctrl_pkg`:
  - `typedef enum logic {FLUSH, RUN} btb_ctrl_state_t`
  - `btb_upd_t` struct {pc, target}, parameterised by `PC_BITWIDTH` via package localparam defaults
- Sub-module `btb_update_fifo`: parameterised depth, with push/pop/full/empty/flush.
- FSM and lookup pipeline live in `btb_controller`.

## Test plan
- Reset release:
  - Stimulus: release reset, then update pc=0x40 target=0x1234 and wait; then look up 0x40.
  - Required response: `btb_sync_rst` is high for one cycle after release. The lookup gives hit=1, target=0x1234.
- Cold lookup:
  - Stimulus: look up 0x80 with nothing written.
  - Required response: `lu_rsp_valid` one cycle later with hit=0. `lu_ready` is low in the response cycle.
- RAW hazard:
  - Stimulus: enqueue update pc=0x41; in the drain cycle, look up pc=0x01 (same index, different tag) and also pc=0x41.
  - Required response: both responses give hit=0. A later lookup of 0x41 gives hit=1.
- Backpressure:
  - Stimulus: hold `clk_en=0` and push 4 updates.
  - Required response: `upd_ready` drops after the 4th. After `clk_en=1`, 4 consecutive `btb_we` pulses occur in FIFO order.
- Flush mid-traffic:
  - Stimulus: queue 3 updates, assert `flush_req` during a pending lookup.
  - Required response: the response gives hit=0. The queue is discarded, so no `btb_we` after the flush. Subsequent lookups miss.
- Stall:
  - Stimulus: drop `clk_en` during the response cycle for 3 cycles.
  - Required response: the response holds its value with a stable `btb_r_address`; there is no double accept.

Source files
------------

// File: rtl/btb_ctrl_pkg.sv
// rtl/btb_ctrl_pkg.sv - shared types and defaults for the BTB sequencer
package btb_ctrl_pkg;

   localparam int PC_BITWIDTH_DEF     = 30;
   localparam int LOW_PC_BITWIDTH_DEF = 6;
   localparam int UPD_DEPTH_DEF       = 4;

   // FLUSH drives the BTB reset for one cycle; RUN serves lookups and updates
   typedef enum logic {
      FLUSH = 1'b0,
      RUN   = 1'b1
   } btb_ctrl_state_t;

   // One resolved branch waiting to be written into the BTB
   typedef struct packed {
      logic [PC_BITWIDTH_DEF-1:0] pc;
      logic [PC_BITWIDTH_DEF-1:0] target;
   } btb_upd_t;

endpackage

// File: rtl/btb_update_fifo.sv
// rtl/btb_update_fifo.sv - circular queue of resolved-branch updates
module btb_update_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 60
) (
   input  logic              clk,
   input  logic              sync_rst_n,
   input  logic              i_flush,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_data,
   output logic              o_full,
   output logic              o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] C_FULL_CNT = (PTR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W:0]    r_count;

   // Payload storage; contents are only meaningful between push and pop
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers wrap naturally; flush discards everything still queued
   always_ff @(posedge clk) begin
      if (!sync_rst_n || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_full  = (r_count == C_FULL_CNT);
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/btb_controller.sv
// rtl/btb_controller.sv - fetch/execute sequencer for the branch target buffer
module btb_controller
   import btb_ctrl_pkg::*;
#(
   parameter int PC_BITWIDTH     = PC_BITWIDTH_DEF,
   parameter int LOW_PC_BITWIDTH = LOW_PC_BITWIDTH_DEF,
   parameter int UPD_DEPTH       = UPD_DEPTH_DEF
) (
   input  logic                   clk,
   input  logic                   sync_rst_n,
   input  logic                   clk_en,
   input  logic                   lu_valid,
   output logic                   lu_ready,
   input  logic [PC_BITWIDTH-1:0] lu_pc,
   output logic                   lu_rsp_valid,
   output logic                   lu_rsp_hit,
   output logic [PC_BITWIDTH-1:0] lu_rsp_target,
   input  logic                   upd_valid,
   output logic                   upd_ready,
   input  logic [PC_BITWIDTH-1:0] upd_pc,
   input  logic [PC_BITWIDTH-1:0] upd_target,
   input  logic                   flush_req,
   output logic                   flush_busy,
   output logic                   btb_clk_en,
   output logic                   btb_sync_rst,
   output logic                   btb_we,
   output logic [PC_BITWIDTH-1:0] btb_r_address,
   output logic [PC_BITWIDTH-1:0] btb_w_address,
   output logic [PC_BITWIDTH-1:0] btb_data_in,
   input  logic [PC_BITWIDTH-1:0] btb_data_out,
   input  logic                   btb_miss
);

   btb_ctrl_state_t r_state;
   btb_ctrl_state_t w_state_nxt;

   logic                     r_rsp_pend;
   logic                     r_kill;
   logic [PC_BITWIDTH-1:0]   r_lu_pc;

   logic                     w_run;
   logic                     w_enter_flush;
   logic                     w_lu_acc;
   logic                     w_push;
   logic                     w_pop;
   logic                     w_same_idx;
   logic                     w_fifo_full;
   logic                     w_fifo_empty;
   logic [2*PC_BITWIDTH-1:0] w_fifo_wdata;
   logic [2*PC_BITWIDTH-1:0] w_fifo_rdata;

   assign w_run         = (r_state == RUN);
   assign w_enter_flush = w_run & flush_req & clk_en;

   // State register; a stall freezes the FSM, reset always lands in FLUSH
   always_ff @(posedge clk) begin
      if (!sync_rst_n) begin
         r_state <= FLUSH;
      end else if (clk_en) begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and handshake readiness; flush_req masks every new handshake
   always_comb begin
      w_state_nxt = r_state;
      flush_busy  = 1'b0;
      lu_ready    = 1'b0;
      upd_ready   = 1'b0;
      case (r_state)
         FLUSH: begin
            w_state_nxt = RUN;
            flush_busy  = 1'b1;
         end
         RUN: begin
            lu_ready  = ~r_rsp_pend & ~flush_req;
            upd_ready = ~w_fifo_full & ~flush_req;
            if (flush_req) begin
               w_state_nxt = FLUSH;
            end
         end
      endcase
   end

   assign btb_sync_rst = ~sync_rst_n | flush_busy;
   assign btb_clk_en   = clk_en;

   // Lookup accept drives the BTB read port directly so data arrives next cycle
   assign w_lu_acc      = lu_valid & lu_ready & clk_en;
   assign btb_r_address = w_lu_acc ? lu_pc : r_lu_pc;

   // A write landing on the looked-up index on the accept edge leaves the read
   // buffer stale while the tag is already new, so that response must not hit
   assign w_same_idx = btb_we &
                       (btb_w_address[LOW_PC_BITWIDTH-1:0] == lu_pc[LOW_PC_BITWIDTH-1:0]);

   // Response pipeline: pending flag, kill flag and the held read address
   always_ff @(posedge clk) begin
      if (!sync_rst_n) begin
         r_rsp_pend <= 1'b0;
         r_kill     <= 1'b0;
         r_lu_pc    <= '0;
      end else if (clk_en) begin
         r_rsp_pend <= w_lu_acc;
         r_kill     <= w_lu_acc & (w_same_idx | w_enter_flush);
         if (w_lu_acc) begin
            r_lu_pc <= lu_pc;
         end
      end
   end

   assign lu_rsp_valid  = r_rsp_pend;
   assign lu_rsp_hit    = r_rsp_pend & ~btb_miss & ~r_kill;
   assign lu_rsp_target = btb_data_out;

   // Execute keeps delivering resolved branches during a stall; only the
   // drain into the BTB waits for clk_en
   assign w_push       = upd_valid & upd_ready;
   assign w_pop        = w_run & ~w_fifo_empty & clk_en;
   assign w_fifo_wdata = {upd_pc, upd_target};

   btb_update_fifo #(
      .DEPTH  (UPD_DEPTH),
      .DATA_W (2 * PC_BITWIDTH)
   ) u_upd_fifo (
      .clk        (clk),
      .sync_rst_n (sync_rst_n),
      .i_flush    (w_enter_flush),
      .i_push     (w_push),
      .i_data     (w_fifo_wdata),
      .i_pop      (w_pop),
      .o_data     (w_fifo_rdata),
      .o_full     (w_fifo_full),
      .o_empty    (w_fifo_empty)
   );

   assign btb_we                       = w_pop;
   assign {btb_w_address, btb_data_in} = w_fifo_rdata;

endmodule

// File: tb/tb_btb_controller.sv
// tb/tb_btb_controller.sv - directed self-checking bench for btb_controller
module tb_btb_controller;
   import btb_ctrl_pkg::*;

   localparam int PCW   = 30;
   localparam int LOW   = 6;
   localparam int DEPTH = 4;

   logic           clk = 1'b0;
   logic           sync_rst_n;
   logic           clk_en;
   logic           lu_valid;
   logic           lu_ready;
   logic [PCW-1:0] lu_pc;
   logic           lu_rsp_valid;
   logic           lu_rsp_hit;
   logic [PCW-1:0] lu_rsp_target;
   logic           upd_valid;
   logic           upd_ready;
   logic [PCW-1:0] upd_pc;
   logic [PCW-1:0] upd_target;
   logic           flush_req;
   logic           flush_busy;
   logic           btb_clk_en;
   logic           btb_sync_rst;
   logic           btb_we;
   logic [PCW-1:0] btb_r_address;
   logic [PCW-1:0] btb_w_address;
   logic [PCW-1:0] btb_data_in;
   logic [PCW-1:0] btb_data_out;
   logic           btb_miss;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   btb_controller #(
      .PC_BITWIDTH     (PCW),
      .LOW_PC_BITWIDTH (LOW),
      .UPD_DEPTH       (DEPTH)
   ) dut (
      .clk           (clk),
      .sync_rst_n    (sync_rst_n),
      .clk_en        (clk_en),
      .lu_valid      (lu_valid),
      .lu_ready      (lu_ready),
      .lu_pc         (lu_pc),
      .lu_rsp_valid  (lu_rsp_valid),
      .lu_rsp_hit    (lu_rsp_hit),
      .lu_rsp_target (lu_rsp_target),
      .upd_valid     (upd_valid),
      .upd_ready     (upd_ready),
      .upd_pc        (upd_pc),
      .upd_target    (upd_target),
      .flush_req     (flush_req),
      .flush_busy    (flush_busy),
      .btb_clk_en    (btb_clk_en),
      .btb_sync_rst  (btb_sync_rst),
      .btb_we        (btb_we),
      .btb_r_address (btb_r_address),
      .btb_w_address (btb_w_address),
      .btb_data_in   (btb_data_in),
      .btb_data_out  (btb_data_out),
      .btb_miss      (btb_miss)
   );

   // Behavioural BTB: registered data read, combinational tag compare
   logic [PCW-1:0]     m_data [64];
   logic [PCW-LOW-1:0] m_tag  [64];
   logic [63:0]        m_val;
   logic [PCW-1:0]     m_rbuf;

   always @(posedge clk) begin
      if (btb_sync_rst) begin
         m_val <= '0;
      end else if (btb_clk_en && btb_we) begin
         m_val[btb_w_address[LOW-1:0]]  <= 1'b1;
         m_tag[btb_w_address[LOW-1:0]]  <= btb_w_address[PCW-1:LOW];
         m_data[btb_w_address[LOW-1:0]] <= btb_data_in;
      end
      if (btb_clk_en) begin
         m_rbuf <= m_data[btb_r_address[LOW-1:0]];
      end
   end

   assign btb_data_out = m_rbuf;
   assign btb_miss     = ~m_val[btb_r_address[LOW-1:0]] |
                         (m_tag[btb_r_address[LOW-1:0]] != btb_r_address[PCW-1:LOW]);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic do_lookup(input logic [PCW-1:0] pc, input logic exp_hit,
                            input logic [PCW-1:0] exp_tgt, input string tag);
      lu_valid = 1'b1;
      lu_pc    = pc;
      smp();
      chk({tag, ".ready"}, 32'(lu_ready), 32'd1);
      chk({tag, ".raddr"}, 32'(btb_r_address), 32'(pc));
      step();
      lu_valid = 1'b0;
      smp();
      chk({tag, ".rsp_valid"}, 32'(lu_rsp_valid), 32'd1);
      chk({tag, ".hit"}, 32'(lu_rsp_hit), 32'(exp_hit));
      if (exp_hit) chk({tag, ".target"}, 32'(lu_rsp_target), 32'(exp_tgt));
      chk({tag, ".ready_rsp"}, 32'(lu_ready), 32'd0);
      step();
   endtask

   btb_upd_t bp_exp [4];

   initial begin
      bp_exp[0] = '{pc: 30'h10, target: 30'hA0};
      bp_exp[1] = '{pc: 30'h11, target: 30'hA1};
      bp_exp[2] = '{pc: 30'h12, target: 30'hA2};
      bp_exp[3] = '{pc: 30'h13, target: 30'hA3};

      sync_rst_n = 1'b0;
      clk_en     = 1'b1;
      lu_valid   = 1'b0;
      lu_pc      = '0;
      upd_valid  = 1'b0;
      upd_pc     = '0;
      upd_target = '0;
      flush_req  = 1'b0;
      repeat (3) step();

      // Reset state
      smp();
      chk("rst.sync_rst", 32'(btb_sync_rst), 32'd1);
      chk("rst.flush_busy", 32'(flush_busy), 32'd1);
      chk("rst.rsp_valid", 32'(lu_rsp_valid), 32'd0);
      chk("rst.rsp_hit", 32'(lu_rsp_hit), 32'd0);
      chk("rst.we", 32'(btb_we), 32'd0);
      chk("rst.lu_ready", 32'(lu_ready), 32'd0);
      chk("rst.upd_ready", 32'(upd_ready), 32'd0);
      step();

      // Release: one FLUSH cycle, then RUN
      sync_rst_n = 1'b1;
      smp();
      chk("rel.sync_rst", 32'(btb_sync_rst), 32'd1);
      chk("rel.flush_busy", 32'(flush_busy), 32'd1);
      chk("rel.lu_ready", 32'(lu_ready), 32'd0);
      step();
      upd_valid = 1'b1; upd_pc = 30'h40; upd_target = 30'h1234;
      smp();
      chk("run.sync_rst", 32'(btb_sync_rst), 32'd0);
      chk("run.flush_busy", 32'(flush_busy), 32'd0);
      chk("run.upd_ready", 32'(upd_ready), 32'd1);
      step();
      upd_valid = 1'b0;
      smp();
      chk("drain.we", 32'(btb_we), 32'd1);
      chk("drain.waddr", 32'(btb_w_address), 32'h40);
      chk("drain.wdata", 32'(btb_data_in), 32'h1234);
      step();
      do_lookup(30'h40, 1'b1, 30'h1234, "lu40");

      // Cold lookup: same index as 0x40, different tag
      do_lookup(30'h80, 1'b0, '0, "cold80");

      // RAW: lookup of a same-index address on the drain edge
      upd_valid = 1'b1; upd_pc = 30'h41; upd_target = 30'h5555;
      step();
      upd_valid = 1'b0;
      lu_valid  = 1'b1; lu_pc = 30'h01;
      smp();
      chk("rawA.we", 32'(btb_we), 32'd1);
      step();
      lu_valid = 1'b0;
      smp();
      chk("rawA.rsp_valid", 32'(lu_rsp_valid), 32'd1);
      chk("rawA.hit", 32'(lu_rsp_hit), 32'd0);
      step();
      upd_valid = 1'b1; upd_pc = 30'h41; upd_target = 30'h6666;
      step();
      upd_valid = 1'b0;
      lu_valid  = 1'b1; lu_pc = 30'h41;
      smp();
      chk("rawB.we", 32'(btb_we), 32'd1);
      step();
      lu_valid = 1'b0;
      smp();
      chk("rawB.hit", 32'(lu_rsp_hit), 32'd0);
      chk("rawB.stale_target", 32'(lu_rsp_target), 32'h5555);
      step();
      do_lookup(30'h41, 1'b1, 30'h6666, "raw.after");

      // Backpressure: fill the queue while stalled, then drain in order
      clk_en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         upd_valid = 1'b1; upd_pc = bp_exp[k].pc; upd_target = bp_exp[k].target;
         smp();
         chk($sformatf("bp.ready%0d", k), 32'(upd_ready), 32'd1);
         chk($sformatf("bp.we_stall%0d", k), 32'(btb_we), 32'd0);
         step();
      end
      upd_pc = 30'h14; upd_target = 30'hA4;
      smp();
      chk("bp.full", 32'(upd_ready), 32'd0);
      step();
      upd_valid = 1'b0;
      clk_en    = 1'b1;
      smp();
      chk("bp.full_drain0", 32'(upd_ready), 32'd0);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("bp.we%0d", k), 32'(btb_we), 32'd1);
         chk($sformatf("bp.waddr%0d", k), 32'(btb_w_address), 32'(bp_exp[k].pc));
         chk($sformatf("bp.wdata%0d", k), 32'(btb_data_in), 32'(bp_exp[k].target));
         step();
         smp();
      end
      chk("bp.we_done", 32'(btb_we), 32'd0);
      step();

      // Flush mid-traffic
      clk_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         upd_valid = 1'b1; upd_pc = 30'h20 + 30'(k); upd_target = 30'hB0 + 30'(k);
         step();
      end
      upd_valid = 1'b0;
      clk_en    = 1'b1;
      lu_valid  = 1'b1; lu_pc = 30'h22;
      smp();
      chk("fl.we0_addr", 32'(btb_w_address), 32'h20);
      chk("fl.lu_ready", 32'(lu_ready), 32'd1);
      step();
      lu_valid  = 1'b0;
      flush_req = 1'b1;
      smp();
      chk("fl.rsp_valid", 32'(lu_rsp_valid), 32'd1);
      chk("fl.hit", 32'(lu_rsp_hit), 32'd0);
      chk("fl.upd_ready", 32'(upd_ready), 32'd0);
      chk("fl.we1_addr", 32'(btb_w_address), 32'h21);
      step();
      flush_req = 1'b0;
      smp();
      chk("fl.busy", 32'(flush_busy), 32'd1);
      chk("fl.sync_rst", 32'(btb_sync_rst), 32'd1);
      chk("fl.we_in_flush", 32'(btb_we), 32'd0);
      chk("fl.rsp_gone", 32'(lu_rsp_valid), 32'd0);
      step();
      smp();
      chk("fl.busy_end", 32'(flush_busy), 32'd0);
      chk("fl.we_after0", 32'(btb_we), 32'd0);
      step();
      smp();
      chk("fl.we_after1", 32'(btb_we), 32'd0);
      step();
      do_lookup(30'h20, 1'b0, '0, "fl.miss20");
      do_lookup(30'h40, 1'b0, '0, "fl.miss40");

      // Stall during the response cycle
      upd_valid = 1'b1; upd_pc = 30'h33; upd_target = 30'hC3;
      step();
      upd_valid = 1'b0;
      step();
      lu_valid = 1'b1; lu_pc = 30'h33;
      step();
      clk_en = 1'b0;
      lu_pc  = 30'h99;
      for (int k = 0; k < 3; k++) begin
         smp();
         chk($sformatf("st.valid%0d", k), 32'(lu_rsp_valid), 32'd1);
         chk($sformatf("st.hit%0d", k), 32'(lu_rsp_hit), 32'd1);
         chk($sformatf("st.target%0d", k), 32'(lu_rsp_target), 32'hC3);
         chk($sformatf("st.raddr%0d", k), 32'(btb_r_address), 32'h33);
         chk($sformatf("st.ready%0d", k), 32'(lu_ready), 32'd0);
         step();
      end
      clk_en   = 1'b1;
      lu_valid = 1'b0;
      smp();
      chk("st.valid_release", 32'(lu_rsp_valid), 32'd1);
      step();
      smp();
      chk("st.no_double", 32'(lu_rsp_valid), 32'd0);
      step();

      // Reset mid-response drops the pending response
      lu_valid = 1'b1; lu_pc = 30'h33;
      step();
      lu_valid   = 1'b0;
      sync_rst_n = 1'b0;
      smp();
      chk("mr.sync_rst", 32'(btb_sync_rst), 32'd1);
      step();
      smp();
      chk("mr.rsp_dropped", 32'(lu_rsp_valid), 32'd0);
      chk("mr.flush_busy", 32'(flush_busy), 32'd1);
      step();
      sync_rst_n = 1'b1;
      step();
      smp();
      chk("mr.run", 32'(flush_busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
